// File: rtl/asr_rcv_pkg.sv
// Shared constants, FSM state types and write-request payload for the ASR receive AXI4-Lite slave.
package asr_rcv_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned STRB_W   = DATA_W / 8;
  localparam int unsigned NUM_REGS = 4;
  localparam int unsigned IDX_W    = 2;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  localparam logic [IDX_W-1:0] REG_CTRL    = 2'd0;
  localparam logic [IDX_W-1:0] REG_SCRATCH = 2'd1;
  localparam logic [IDX_W-1:0] REG_RESULT  = 2'd2;
  localparam logic [IDX_W-1:0] REG_STATUS  = 2'd3;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } wr_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_e;

  // Write request as held between the AW and W halves arriving
  typedef struct packed {
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] strb;
  } wr_req_t;

endpackage

// File: rtl/asr_rcv_strb_merge.sv
// Combinational byte-strobe merge: bytes with strb set come from new_data, the rest keep old_data.
module asr_rcv_strb_merge
  import asr_rcv_pkg::*;
(
  input  logic [DATA_W-1:0] old_data,
  input  logic [DATA_W-1:0] new_data,
  input  logic [STRB_W-1:0] strb,
  output logic [DATA_W-1:0] merged_c
);

  always_comb begin
    merged_c = old_data;
    for (int k = 0; k < int'(STRB_W); k++) begin
      if (strb[k]) merged_c[k*8 +: 8] = new_data[k*8 +: 8];
    end
  end

endmodule

// File: rtl/asr_rcv_axil_slave.sv
// AXI4-Lite slave exposing a 4 x 32-bit register bank to the ASR receive logic.
// Define ASR_RCV_RESULT_EN to add the hardware result-capture port into reg2/reg3[0].
module asr_rcv_axil_slave
  import asr_rcv_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [(C_S_AXI_DATA_WIDTH/8)-1:0] S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
`ifdef ASR_RCV_RESULT_EN
  input  logic                              asr_result_valid,
  input  logic [DATA_W-1:0]                 asr_result,
`endif
  output logic [C_S_AXI_DATA_WIDTH-1:0]     reg0_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     reg1_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     reg2_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     reg3_o
);

  wr_state_e wr_state_q, wr_state_d;
  rd_state_e rd_state_q, rd_state_d;

  logic awready_q, awready_d;
  logic wready_q,  wready_d;
  logic bvalid_q,  bvalid_d;
  logic arready_q, arready_d;
  logic rvalid_q,  rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic    aw_held_q, aw_held_d;
  logic    w_held_q,  w_held_d;
  wr_req_t req_q, req_d;
  wr_req_t wr_c;

  logic aw_hs_c, w_hs_c, ar_hs_c, do_write_c;

  logic [DATA_W-1:0] regs_q   [NUM_REGS];
  logic [DATA_W-1:0] regs_d   [NUM_REGS];
  logic [DATA_W-1:0] merged_c [NUM_REGS];

  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

  // Handshakes and the effective write request (live channel value wins over the held copy)
  always_comb begin
    aw_hs_c    = S_AXI_AWVALID & awready_q;
    w_hs_c     = S_AXI_WVALID & wready_q;
    ar_hs_c    = S_AXI_ARVALID & arready_q;
    wr_c       = req_q;
    if (aw_hs_c) wr_c.idx = S_AXI_AWADDR[3:2];
    if (w_hs_c) begin
      wr_c.data = S_AXI_WDATA;
      wr_c.strb = S_AXI_WSTRB;
    end
    do_write_c = (wr_state_q == W_IDLE) & (aw_held_q | aw_hs_c) & (w_held_q | w_hs_c);
  end

  for (genvar g = 0; g < int'(NUM_REGS); g++) begin : g_merge
    asr_rcv_strb_merge u_merge (
      .old_data (regs_q[g]),
      .new_data (wr_c.data),
      .strb     (wr_c.strb),
      .merged_c (merged_c[g])
    );
  end

  // State register
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      wr_state_q <= W_IDLE;
      rd_state_q <= R_IDLE;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      req_q      <= '0;
      for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      req_q      <= req_d;
      for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= regs_d[i];
    end
  end

  // Next-state logic
  always_comb begin
    wr_state_d = wr_state_q;
    rd_state_d = rd_state_q;
    case (wr_state_q)
      W_IDLE:  if (do_write_c) wr_state_d = W_RESP;
      W_RESP:  if (bvalid_q & S_AXI_BREADY) wr_state_d = W_IDLE;
      default: wr_state_d = W_IDLE;
    endcase
    case (rd_state_q)
      R_IDLE:  if (ar_hs_c) rd_state_d = R_DATA;
      R_DATA:  if (rvalid_q & S_AXI_RREADY) rd_state_d = R_IDLE;
      default: rd_state_d = R_IDLE;
    endcase
  end

  // Registered-output and register-bank next values
  always_comb begin
    req_d     = req_q;
    aw_held_d = (aw_held_q | aw_hs_c) & ~do_write_c;
    w_held_d  = (w_held_q | w_hs_c) & ~do_write_c;
    if (aw_hs_c) req_d.idx = wr_c.idx;
    if (w_hs_c) begin
      req_d.data = wr_c.data;
      req_d.strb = wr_c.strb;
    end
    awready_d = (wr_state_d == W_IDLE) & ~aw_held_d;
    wready_d  = (wr_state_d == W_IDLE) & ~w_held_d;
    bvalid_d  = (wr_state_d == W_RESP);
    arready_d = (rd_state_d == R_IDLE);
    rvalid_d  = (rd_state_d == R_DATA);
    rdata_d   = ar_hs_c ? regs_q[S_AXI_ARADDR[3:2]] : rdata_q;

    regs_d = regs_q;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      if (do_write_c && (wr_c.idx == IDX_W'(i))) regs_d[i] = merged_c[i];
    end
`ifdef ASR_RCV_RESULT_EN
    // reg3[0] is a sticky flag: hardware sets it, writing 1 clears it, set beats clear
    regs_d[REG_STATUS][0] = regs_q[REG_STATUS][0];
    if (do_write_c && (wr_c.idx == REG_STATUS) && wr_c.strb[0] && wr_c.data[0])
      regs_d[REG_STATUS][0] = 1'b0;
    if (asr_result_valid) begin
      regs_d[REG_RESULT]    = asr_result;
      regs_d[REG_STATUS][0] = 1'b1;
    end
`endif
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = RESP_OKAY;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = RESP_OKAY;

  assign reg0_o = regs_q[REG_CTRL];
  assign reg1_o = regs_q[REG_SCRATCH];
  assign reg2_o = regs_q[REG_RESULT];
  assign reg3_o = regs_q[REG_STATUS];

endmodule

// File: tb/tb_asr_rcv_axil_slave.sv
// Directed self-checking bench for asr_rcv_axil_slave; covers ASR_RCV_RESULT_EN when defined.
module tb_asr_rcv_axil_slave;

  logic        tb_ACLK;
  logic        areset;
  logic [3:0]  awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [3:0]  araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] reg0, reg1, reg2, reg3;
`ifdef ASR_RCV_RESULT_EN
  logic        res_valid;
  logic [31:0] res_data;
`endif

  int total = 0;
  int bad   = 0;

  asr_rcv_axil_slave dut (
    .S_AXI_ACLK    (tb_ACLK),
    .S_AXI_ARESET  (areset),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWPROT  (awprot),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARPROT  (arprot),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
`ifdef ASR_RCV_RESULT_EN
    .asr_result_valid (res_valid),
    .asr_result       (res_data),
`endif
    .reg0_o        (reg0),
    .reg1_o        (reg1),
    .reg2_o        (reg2),
    .reg3_o        (reg3)
  );

  initial tb_ACLK = 1'b0;
  always #5 tb_ACLK = ~tb_ACLK;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge tb_ACLK);
    #1;
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    int   n;
    logic aw_done, w_done, aw_fire, w_fire;
    n = 0; aw_done = 1'b0; w_done = 1'b0;
    awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1; bready = 1'b1;
    while (!(aw_done && w_done) && n < 50) begin
      aw_fire = awvalid & awready;
      w_fire  = wvalid & wready;
      tick(); n++;
      if (aw_fire) begin aw_done = 1'b1; awvalid = 1'b0; end
      if (w_fire)  begin w_done  = 1'b1; wvalid  = 1'b0; end
    end
    awvalid = 1'b0; wvalid = 1'b0;
    check("wr_addr_data_accepted", 32'({aw_done, w_done}), 32'h3);
    while (!bvalid && n < 50) begin tick(); n++; end
    check("wr_bvalid", 32'(bvalid), 32'h1);
    check("wr_bresp", 32'(bresp), 32'h0);
    tick();
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] a, input logic [31:0] exp, input string tag);
    int n;
    n = 0;
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    while (!arready && n < 50) begin tick(); n++; end
    check({tag, "_arready"}, 32'(arready), 32'h1);
    tick();
    arvalid = 1'b0;
    while (!rvalid && n < 50) begin tick(); n++; end
    check({tag, "_rvalid"}, 32'(rvalid), 32'h1);
    check({tag, "_rdata"}, rdata, exp);
    check({tag, "_rresp"}, 32'(rresp), 32'h0);
    tick();
    rready = 1'b0;
  endtask

  initial begin
    areset = 1'b1;
    awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
    bready = 1'b0; araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
`ifdef ASR_RCV_RESULT_EN
    res_valid = 1'b0; res_data = '0;
`endif
    repeat (3) tick();

    // Reset state
    check("rst_awready", 32'(awready), 32'h0);
    check("rst_wready", 32'(wready), 32'h0);
    check("rst_arready", 32'(arready), 32'h0);
    check("rst_bvalid", 32'(bvalid), 32'h0);
    check("rst_rvalid", 32'(rvalid), 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_regs", reg0 | reg1 | reg2 | reg3, 32'h0);
    areset = 1'b0;
    repeat (2) tick();
    check("post_rst_ready", 32'({awready, wready, arready}), 32'h7);

    // Basic write/read of all four registers
    axi_write(4'h0, 32'h0101FFFF, 4'hF);
    axi_read(4'h0, 32'h0101FFFF, "rd_reg0");
    axi_write(4'h4, 32'hABCD0001, 4'hF);
    axi_read(4'h4, 32'hABCD0001, "rd_reg1");
    axi_write(4'h8, 32'hDEAD0011, 4'hF);
    axi_read(4'h8, 32'hDEAD0011, "rd_reg2");
    axi_write(4'hC, 32'hBEEF0011, 4'hF);
`ifdef ASR_RCV_RESULT_EN
    axi_read(4'hC, 32'hBEEF0010, "rd_reg3");
    check("reg3_o", reg3, 32'hBEEF0010);
`else
    axi_read(4'hC, 32'hBEEF0011, "rd_reg3");
    check("reg3_o", reg3, 32'hBEEF0011);
`endif
    check("reg0_o", reg0, 32'h0101FFFF);
    check("reg1_o", reg1, 32'hABCD0001);
    check("reg2_o", reg2, 32'hDEAD0011);

    // W ahead of AW by three cycles
    wdata = 32'h12345678; wstrb = 4'hF; wvalid = 1'b1;
    check("wfirst_wready", 32'(wready), 32'h1);
    tick();
    wvalid = 1'b0;
    check("wfirst_wready_held", 32'(wready), 32'h0);
    check("wfirst_awready", 32'(awready), 32'h1);
    check("wfirst_bvalid0", 32'(bvalid), 32'h0);
    repeat (2) tick();
    check("wfirst_bvalid1", 32'(bvalid), 32'h0);
    awaddr = 4'h4; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    check("wfirst_bvalid_after_aw", 32'(bvalid), 32'h1);
    check("wfirst_awready_resp", 32'(awready), 32'h0);
    bready = 1'b1;
    tick();
    bready = 1'b0;
    check("wfirst_bvalid_done", 32'(bvalid), 32'h0);
    check("wfirst_readies_back", 32'({awready, wready}), 32'h3);
    axi_read(4'h4, 32'h12345678, "rd_wfirst");

    // BREADY held low with a second AW waiting
    awaddr = 4'h0; wdata = 32'hCAFEF00D; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    awaddr = 4'h8; awvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bhold_bvalid", 32'(bvalid), 32'h1);
      check("bhold_awready", 32'(awready), 32'h0);
      check("bhold_wready", 32'(wready), 32'h0);
      tick();
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    check("bhold_bvalid_done", 32'(bvalid), 32'h0);
    check("bhold_aw2_not_taken", 32'(awready), 32'h1);
    awvalid = 1'b0;
    axi_write(4'h8, 32'h00000055, 4'hF);
    axi_read(4'h8, 32'h00000055, "rd_aw2");

    // Byte strobes
    axi_write(4'h4, 32'hFFFFFFFF, 4'hF);
    axi_write(4'h4, 32'h00000000, 4'b0101);
    axi_read(4'h4, 32'hFF00FF00, "rd_strb");
    axi_write(4'h4, 32'h12345678, 4'h0);
    axi_read(4'h4, 32'hFF00FF00, "rd_strb0");

    // RREADY held low, then reset during the hold
    araddr = 4'h0; arvalid = 1'b1; rready = 1'b0;
    tick();
    arvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("rhold_rvalid", 32'(rvalid), 32'h1);
      check("rhold_rdata", rdata, 32'hCAFEF00D);
      check("rhold_arready", 32'(arready), 32'h0);
      tick();
    end
    areset = 1'b1;
    tick();
    check("midrst_rvalid", 32'(rvalid), 32'h0);
    check("midrst_rdata", rdata, 32'h0);
    check("midrst_reg0", reg0, 32'h0);
    areset = 1'b0;
    repeat (2) tick();
    check("midrst_readies", 32'({awready, wready, arready}), 32'h7);

    // Low address bits ignored
    axi_write(4'h6, 32'h000000A5, 4'hF);
    axi_read(4'h4, 32'h000000A5, "rd_alias");

    // Same-cycle read and write of one register returns the old value
    awaddr = 4'h4; wdata = 32'h11112222; wstrb = 4'hF; araddr = 4'h4;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b1; rready = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    check("conc_bvalid", 32'(bvalid), 32'h1);
    check("conc_rvalid", 32'(rvalid), 32'h1);
    check("conc_rdata_old", rdata, 32'h000000A5);
    tick();
    bready = 1'b0; rready = 1'b0;
    check("conc_done", 32'({bvalid, rvalid}), 32'h0);
    axi_read(4'h4, 32'h11112222, "rd_conc_new");

`ifdef ASR_RCV_RESULT_EN
    // Hardware result capture and sticky flag
    res_data = 32'h00000042; res_valid = 1'b1;
    tick();
    res_valid = 1'b0;
    check("res_reg2_o", reg2, 32'h00000042);
    axi_read(4'h8, 32'h00000042, "rd_res");
    axi_read(4'hC, 32'h00000001, "rd_flag_set");
    axi_write(4'hC, 32'h00000001, 4'hF);
    axi_read(4'hC, 32'h00000000, "rd_flag_clr");

    // Set beats same-cycle clear
    awaddr = 4'hC; wdata = 32'h00000001; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    res_data = 32'h00000099; res_valid = 1'b1;
    tick();
    res_valid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    check("setclr_bvalid", 32'(bvalid), 32'h1);
    tick();
    bready = 1'b0;
    axi_read(4'hC, 32'h00000001, "rd_setclr");
    axi_read(4'h8, 32'h00000099, "rd_setclr_res");

    // Hardware write beats same-cycle AXI write to reg2
    awaddr = 4'h8; wdata = 32'h00000077; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    res_data = 32'h00000088; res_valid = 1'b1;
    tick();
    res_valid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    tick();
    bready = 1'b0;
    axi_read(4'h8, 32'h00000088, "rd_hw_wins");
    axi_read(4'hC, 32'h00000001, "rd_flag_sticky");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/asr_rcv_axil_slave.md
Name: asr_rcv_axil_slave

Overview:
- AXI4-Lite responder (slave) for the ASR receive peripheral: a 4 x 32-bit register bank that answers the AXI4-Lite master's single-beat writes and reads.
- Sits between the interconnect/master port and the ASR receive logic; exports the register contents as wires to that logic.
- Full handshake compliance: AW and W accepted independently, B and R held until accepted, one outstanding transaction per direction.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 supported.
- C_S_AXI_ADDR_WIDTH, 4, byte-address width; bits [3:2] select the register, bits [1:0] ignored.

Ports:
- S_AXI_ACLK  in  1  single clock
- S_AXI_ARESET  in  1  synchronous, active-high reset
- S_AXI_AWADDR  in  ADDR  write address
- S_AXI_AWPROT  in  3  ignored
- S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write-address handshake
- S_AXI_WDATA  in  32  write data
- S_AXI_WSTRB  in  4  byte enables
- S_AXI_WVALID / S_AXI_WREADY  in / out  1  write-data handshake
- S_AXI_BRESP  out  2  always 2'b00 (OKAY)
- S_AXI_BVALID / S_AXI_BREADY  out / in  1  write-response handshake
- S_AXI_ARADDR  in  ADDR  read address
- S_AXI_ARPROT  in  3  ignored
- S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  read-address handshake
- S_AXI_RDATA  out  32  read data
- S_AXI_RRESP  out  2  always 2'b00 (OKAY)
- S_AXI_RVALID / S_AXI_RREADY  out / in  1  read-data handshake
- reg0_o..reg3_o  out  32 each  current register contents to ASR logic

Behaviour:
- Reset, sampled on the S_AXI_ACLK rising edge while S_AXI_ARESET=1:
  - all READY and VALID outputs low; RDATA = 0; BRESP/RRESP = 0; reg0..reg3 = 0.
  - Reset mid-transaction drops any pending B/R and latched AW/W without a response.
- Write FSM, states W_IDLE, W_RESP:
  - In W_IDLE, AWREADY=1 until an address is latched and WREADY=1 until data+strobe are latched. Either may arrive first, or both in the same cycle.
  - The register write occurs in the cycle both halves are held (the cycle of the second handshake, or the simultaneous one). BVALID rises the next cycle; state moves to W_RESP.
  - In W_RESP, AWREADY=WREADY=0 and BVALID is held until BREADY. On the BVALID&BREADY cycle, return to W_IDLE with READYs high the following cycle.
  - Minimum latency: AW+W handshake in cycle N -> BVALID in N+1.
- Byte strobes: byte k of the target register is updated only if WSTRB[k]=1. WSTRB=0 is legal: it still completes with OKAY and leaves the register unchanged.
- Read FSM, states R_IDLE, R_DATA:
  - In R_IDLE, ARREADY=1. On ARVALID&ARREADY, RDATA latches the selected register and RVALID rises the next cycle; state moves to R_DATA with ARREADY=0.
  - RDATA and RVALID are stable until RREADY; then return to R_IDLE.
  - A read in the same cycle as a write to the same register returns the pre-write value.
- Write and read paths are fully independent; concurrent operation is allowed.
- Address wrap: only bits [3:2] decode, so address 0x10 aliases reg0.

Optional Feature:
- Macro: ASR_RCV_RESULT_EN.
- Defined:
  - Adds ports asr_result_valid (in, 1) and asr_result (in, 32).
  - On asr_result_valid, reg2 <= asr_result and reg3[0] <= 1 (sticky result-ready flag).
  - An AXI write to reg3 with WSTRB[0]=1 and WDATA[0]=1 clears reg3[0]; other reg3 bits are written normally.
  - Hardware write to reg2 wins over a same-cycle AXI write to reg2. A hardware set of reg3[0] wins over a same-cycle clear.
- Undefined: no extra ports; all four registers are plain R/W.

Decomposition:
- Package asr_rcv_pkg holds:
  - the RESP_OKAY=2'b00 constant;
  - register index constants REG_CTRL=0, REG_SCRATCH=1, REG_RESULT=2, REG_STATUS=3;
  - write and read FSM state enums.
- One sub-module is natural: asr_rcv_strb_merge, the combinational byte-strobe merge of old and new data, instantiated once per register.

Test Plan:
- Reset then write 0x0101FFFF, 0xABCD0001, 0xDEAD0011, 0xBEEF0011 to 0x0, 0x4, 0x8, 0xC, each followed by a read -> every BRESP/RRESP=0 and readback matches exactly.
- W presented 3 cycles before AW (addr 0x4, data 0x12345678) -> no BVALID until the cycle after AW is accepted; readback 0x12345678.
- Hold BREADY=0 for 5 cycles -> BVALID stays 1, AWREADY/WREADY stay 0; a second AW is not accepted until after the B handshake.
- Write 0xFFFFFFFF then 0x00000000 with WSTRB=4'b0101 to reg1 -> readback 0xFF00FF00. WSTRB=0 write -> value unchanged, BRESP=0.
- Hold RREADY=0 for 4 cycles after a read of reg0=0xCAFEF00D -> RDATA stable at 0xCAFEF00D. Reset asserted mid-hold -> RVALID=0 and RDATA=0 the next cycle.
- With ASR_RCV_RESULT_EN: pulse asr_result_valid with 0x00000042 -> reg2 reads 0x42 and reg3[0]=1. Write 0x1 to reg3 -> reg3[0]=0. A same-cycle pulse and clear -> reg3[0]=1.
